axis_lfsr_fifo: RTL and testbench
=================================

AXIS_LFSR_FIFO -- requirements
Module: axis_lfsr_fifo

Interface
REQ-001 Parameter DATA_W, default 32: width of every stored word.
REQ-002 Parameter DEPTH, default 16: number of entries; the value SHALL be a power of two, at least 2.
REQ-003 aclk  in  1: single clock; all state SHALL update on its rising edge.
REQ-004 aresetn  in  1: reset, synchronous, active-low.
REQ-005 s_axis_tdata  in  DATA_W: LFSR word from the upstream AXI-Stream master.
REQ-006 s_axis_tvalid  in  1: upstream word valid.
REQ-007 s_axis_tready  out  1: FIFO can accept a word.
REQ-008 drain_en  in  1: permits popping one word per cycle toward the logger.
REQ-009 fifo_data  out  DATA_W: popped word, registered.
REQ-010 fifo_valid  out  1: single-cycle strobe; fifo_data is valid in that cycle; there is no downstream backpressure.
REQ-011 fifo_count  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-012 fifo_full, fifo_empty  out  1: occupancy flags, registered.

Function
REQ-013 Push SHALL occur when s_axis_tvalid && s_axis_tready; the word goes to mem[wr_ptr] and wr_ptr increments.
REQ-014 s_axis_tready SHALL equal !fifo_full && aresetn; a pop in the same cycle SHALL NOT raise tready when full.
REQ-015 Pop SHALL occur when drain_en && !fifo_empty; mem[rd_ptr] is registered into fifo_data and rd_ptr increments.
REQ-016 In the cycle after a pop, fifo_valid SHALL be 1; otherwise it is 0 and fifo_data holds its last value.
REQ-017 Latency: a word pushed at edge N SHALL be poppable at edge N+1 and appear on fifo_valid after edge N+1, i.e. two cycles minimum.
REQ-018 An empty FIFO with a simultaneous push SHALL NOT pop in that cycle (no bypass).
REQ-019 A simultaneous push and pop with fifo_count between 1 and DEPTH-1 SHALL leave fifo_count unchanged.
REQ-020 Pointers are $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-021 fifo_full = (fifo_count==DEPTH); fifo_empty = (fifo_count==0); both SHALL update in the same cycle as fifo_count.
REQ-022 Output order SHALL be strictly first-in, first-out; no word is dropped or duplicated.

Reset
REQ-023 While aresetn=0 at an edge, pointers, fifo_count, fifo_valid and fifo_data SHALL be cleared to 0, fifo_empty set to 1 and fifo_full cleared to 0.
REQ-024 Reset mid-operation SHALL discard all stored words; no pre-reset word is ever emitted afterward; memory contents need not be cleared.
REQ-025 s_axis_tready SHALL be 0 while aresetn=0 and 1 in the first cycle after release.

Configuration
REQ-026 Macro AXIS_FIFO_WORDCNT_EN defined: an extra output total_words [31:0] SHALL count fifo_valid strobes, wrap modulo 2^32 and reset to 0.
REQ-027 Macro absent: the total_words port and its counter SHALL NOT exist; all other behaviour is identical.

Structure
REQ-028 Package axis_fifo_pkg SHALL hold the DATA_W/DEPTH defaults and the count-width constant derivation.
REQ-029 Storage SHALL be a sub-module fifo_mem: simple dual-port, synchronous write, registered read, with no reset on the array.
REQ-030 Pointer, count and flag logic SHALL reside in axis_lfsr_fifo.

Verification
REQ-031 Hold aresetn low for 2 cycles with tvalid=1 -> tready=0, empty=1, count=0, fifo_valid=0; after release -> tready=1.
REQ-032 Push 0x11, 0x22, 0x33 with drain_en=0 -> count=3, no fifo_valid; then set drain_en=1 -> three consecutive fifo_valid strobes carrying 0x11, 0x22, 0x33, then empty=1.
REQ-033 Push 16 words -> full=1 and tready=0; the 17th word is held by the master and accepted the cycle after one pop; output order is preserved.
REQ-034 At count=5, push and pop every cycle for 10 cycles -> count stays 5 throughout; data stays in order.
REQ-035 Stream 40 incrementing words through DEPTH=16 with random drain_en -> the output sequence equals the input sequence (pointer wrap checked).
REQ-036 At count=7, pulse aresetn low for 1 cycle -> empty=1, count=0; no stale word is emitted; with AXIS_FIFO_WORDCNT_EN defined, total_words=0.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// Shared defaults and width helpers for the AXI-Stream LFSR capture FIFO.
// Optional word counter is enabled with the AXIS_FIFO_WORDCNT_EN macro.
package axis_fifo_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 16;

   // Pointer width indexes DEPTH entries; count needs one extra bit to reach DEPTH.
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read.
// The array itself is never reset; only the read register is cleared.
module fifo_mem
   import axis_fifo_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int PTR_W  = ptr_w(DEPTH)
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              wr_en,
   input  logic [PTR_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [PTR_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // rd_data holds its last value between reads.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/axis_lfsr_fifo.sv
// AXI-Stream capture FIFO feeding a logger with a one-cycle valid strobe.
// Define AXIS_FIFO_WORDCNT_EN to add the total_words strobe counter output.
module axis_lfsr_fifo
   import axis_fifo_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int PTR_W  = ptr_w(DEPTH),
   localparam int CNT_W  = cnt_w(DEPTH)
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              drain_en,
   output logic [DATA_W-1:0] fifo_data,
   output logic              fifo_valid,
   output logic [CNT_W-1:0]  fifo_count,
   output logic              fifo_full,
   output logic              fifo_empty
`ifdef AXIS_FIFO_WORDCNT_EN
  ,output logic [31:0]       total_words
`endif
);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_nxt;
   logic             push;
   logic             pop;

   // Handshake: a word transfers on any rising edge where s_axis_tvalid and
   // s_axis_tready are both high; the master holds tdata/tvalid until then.
   // tready depends only on the registered full flag, so a pop in the same
   // cycle never lets a full FIFO accept.
   assign s_axis_tready = !fifo_full && aresetn;
   assign push          = s_axis_tvalid && s_axis_tready;
   assign pop           = drain_en && !fifo_empty && aresetn;

   always_comb begin
      count_nxt = fifo_count;
      if (push && !pop) begin
         count_nxt = fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
         count_nxt = fifo_count - CNT_W'(1);
      end
   end

   // Flags are derived from count_nxt so they move with fifo_count.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         fifo_full  <= 1'b0;
         fifo_empty <= 1'b1;
         fifo_valid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fifo_count <= count_nxt;
         fifo_full  <= (count_nxt == CNT_W'(DEPTH));
         fifo_empty <= (count_nxt == '0);
         fifo_valid <= pop;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .aclk    (aclk),
      .aresetn (aresetn),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (s_axis_tdata),
      .rd_en   (pop),
      .rd_addr (rd_ptr),
      .rd_data (fifo_data)
   );

`ifdef AXIS_FIFO_WORDCNT_EN
   // Counts on pop so the total already includes the strobe now on fifo_valid.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         total_words <= '0;
      end else if (pop) begin
         total_words <= total_words + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_lfsr_fifo.sv
// Directed bench for axis_lfsr_fifo with a queue scoreboard on the output strobe.
// Builds with or without AXIS_FIFO_WORDCNT_EN.
module tb_axis_lfsr_fifo;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;

   logic              aclk;
   logic              aresetn;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic              drain_en;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_valid;
   logic [4:0]        fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
`ifdef AXIS_FIFO_WORDCNT_EN
   logic [31:0]       total_words;
`endif

   int total = 0;
   int bad   = 0;
   logic [DATA_W-1:0] exp_q[$];

   axis_lfsr_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .drain_en      (drain_en),
      .fifo_data     (fifo_data),
      .fifo_valid    (fifo_valid),
      .fifo_count    (fifo_count),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty)
`ifdef AXIS_FIFO_WORDCNT_EN
     ,.total_words   (total_words)
`endif
   );

   // clock / reset
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // driver tasks
   task automatic push_word(input logic [31:0] d, input bit rnd_drain);
      logic acc;
      int   guard;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      guard = 0;
      do begin
         if (rnd_drain) drain_en = 1'($urandom_range(0, 1));
         acc = s_axis_tready;
         tick();
         guard++;
      end while (!acc && guard < 100);
      check("push_accept", 32'(acc), 32'd1);
   endtask

   task automatic drain_all();
      int guard;
      drain_en = 1'b1;
      guard = 0;
      while (!fifo_empty && guard < 64) begin
         tick();
         guard++;
      end
      check("drain_empty", 32'(fifo_empty), 32'd1);
      tick();
      drain_en = 1'b0;
      tick();
      check("sb_flushed", 32'(exp_q.size()), 32'd0);
   endtask

   // scoreboard: records accepted words and checks every strobe
   initial begin
      forever begin
         @(negedge aclk);
         if (fifo_valid === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'(fifo_valid), 32'd0);
            else                   check("fifo_data", fifo_data, exp_q.pop_front());
         end
         if (s_axis_tvalid && s_axis_tready) exp_q.push_back(s_axis_tdata);
      end
   end

   initial begin
      aresetn       = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'hDEAD_BEEF;
      drain_en      = 1'b0;
      tick();
      tick();
      check("rst_tready", 32'(s_axis_tready), 32'd0);
      check("rst_empty",  32'(fifo_empty),    32'd1);
      check("rst_full",   32'(fifo_full),     32'd0);
      check("rst_count",  32'(fifo_count),    32'd0);
      check("rst_valid",  32'(fifo_valid),    32'd0);
      check("rst_data",   fifo_data,          32'd0);
      aresetn       = 1'b1;
      s_axis_tvalid = 1'b0;
      #1;
      check("rel_tready", 32'(s_axis_tready), 32'd1);
`ifdef AXIS_FIFO_WORDCNT_EN
      check("rst_total_words", total_words, 32'd0);
`endif

      // three words held, then drained back-to-back
      push_word(32'h11, 1'b0);
      push_word(32'h22, 1'b0);
      push_word(32'h33, 1'b0);
      s_axis_tvalid = 1'b0;
      check("hold_count", 32'(fifo_count), 32'd3);
      check("hold_empty", 32'(fifo_empty), 32'd0);
      tick();
      check("hold_valid", 32'(fifo_valid), 32'd0);
      check("hold_count2", 32'(fifo_count), 32'd3);
      drain_en = 1'b1;
      tick();
      check("drain1_valid", 32'(fifo_valid), 32'd1);
      check("drain1_data",  fifo_data,       32'h11);
      tick();
      check("drain2_valid", 32'(fifo_valid), 32'd1);
      check("drain2_data",  fifo_data,       32'h22);
      tick();
      check("drain3_valid", 32'(fifo_valid), 32'd1);
      check("drain3_data",  fifo_data,       32'h33);
      check("drain3_empty", 32'(fifo_empty), 32'd1);
      check("drain3_count", 32'(fifo_count), 32'd0);
      tick();
      check("drain4_valid", 32'(fifo_valid), 32'd0);
      check("drain4_data",  fifo_data,       32'h33);

      // minimum latency, no bypass through an empty FIFO
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h5A;
      tick();
      s_axis_tvalid = 1'b0;
      check("lat_e1_valid", 32'(fifo_valid), 32'd0);
      check("lat_e1_count", 32'(fifo_count), 32'd1);
      tick();
      check("lat_e2_valid", 32'(fifo_valid), 32'd1);
      check("lat_e2_data",  fifo_data,       32'h5A);
      check("lat_e2_empty", 32'(fifo_empty), 32'd1);
      drain_en = 1'b0;
      tick();

      // fill to full, 17th word waits for a pop
      for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i), 1'b0);
      s_axis_tdata = 32'h1FF;
      check("full_flag",   32'(fifo_full),     32'd1);
      check("full_tready", 32'(s_axis_tready), 32'd0);
      check("full_count",  32'(fifo_count),    32'd16);
      tick();
      tick();
      check("full_hold_count", 32'(fifo_count), 32'd16);
      drain_en = 1'b1;
      tick();
      drain_en = 1'b0;
      check("pop1_count",  32'(fifo_count),    32'd15);
      check("pop1_tready", 32'(s_axis_tready), 32'd1);
      check("pop1_data",   fifo_data,          32'h100);
      tick();
      s_axis_tvalid = 1'b0;
      check("refill_count", 32'(fifo_count), 32'd16);
      check("refill_full",  32'(fifo_full),  32'd1);
      drain_all();

      // simultaneous push and pop holds occupancy
      for (int i = 0; i < 5; i++) push_word(32'h200 + 32'(i), 1'b0);
      check("pp_start_count", 32'(fifo_count), 32'd5);
      drain_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_axis_tdata = 32'h205 + 32'(i);
         tick();
         check("pp_count", 32'(fifo_count), 32'd5);
      end
      s_axis_tvalid = 1'b0;
      drain_all();

      // 40-word stream with random drain, wraps the pointers
      for (int i = 0; i < 40; i++) push_word(32'h300 + 32'(i), 1'b1);
      s_axis_tvalid = 1'b0;
      drain_all();
`ifdef AXIS_FIFO_WORDCNT_EN
      check("total_words_76", total_words, 32'd76);
`endif

      // reset with 7 words stored
      for (int i = 0; i < 7; i++) push_word(32'h400 + 32'(i), 1'b0);
      s_axis_tvalid = 1'b0;
      check("pre_rst_count", 32'(fifo_count), 32'd7);
      aresetn = 1'b0;
      exp_q.delete();
      tick();
      check("mid_rst_count",  32'(fifo_count),    32'd0);
      check("mid_rst_empty",  32'(fifo_empty),    32'd1);
      check("mid_rst_valid",  32'(fifo_valid),    32'd0);
      check("mid_rst_tready", 32'(s_axis_tready), 32'd0);
      aresetn = 1'b1;
      #1;
      check("mid_rel_tready", 32'(s_axis_tready), 32'd1);
`ifdef AXIS_FIFO_WORDCNT_EN
      check("mid_rst_total_words", total_words, 32'd0);
`endif
      drain_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_valid", 32'(fifo_valid), 32'd0);
      end
      drain_en = 1'b0;

      push_word(32'h77, 1'b0);
      s_axis_tvalid = 1'b0;
      drain_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
